bottle_box_counter: RTL and testbench

- Parametrised successor to the line's 8-bit bottle counter.
- Counts bottles from the fill-line presence sensor and packs them into boxes of MODULO bottles.
- Runs on the system clock with a clock enable, never on a gated clock.
- Adds: input synchronisation and edge detection; up/down counting for reject removal; preset load; box counting; status flags consumed by the packaging FSM and the display decoders.

---
 rtl/bottle_box_counter.sv | 91 +++++++++
 tb/tb_bottle_box_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bottle_box_counter.sv
// bottle_box_counter: counts sensor-detected bottles into boxes of MODULO,
// with reject (down) counting, preset load, box tally and status flags.
module bottle_box_counter #(
    parameter int WIDTH     = 8,
    parameter int MODULO    = 12,
    parameter int BOX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 count_enable,
    input  logic                 sensor_in,
    input  logic                 dir,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    output logic [WIDTH-1:0]     count,
    output logic [BOX_WIDTH-1:0] box_count,
    output logic                 box_done,
    output logic                 box_full,
    output logic                 underflow
);

    localparam longint SPAN = longint'(1) << WIDTH;

    generate
        if (MODULO < 2 || longint'(MODULO) > SPAN) begin : g_bad_modulo
            $error("bottle_box_counter: MODULO out of range");
        end
    endgenerate

    localparam logic [WIDTH-1:0]     TOP     = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]       MOD_W   = (WIDTH + 1)'(MODULO);
    localparam logic [BOX_WIDTH-1:0] BOX_MAX = '1;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             bottle_ev;
    logic [WIDTH-1:0] load_clamped;

    // Chain resets high so a sensor already high at reset release is ignored.
    assign bottle_ev    = s2 & ~s3 & count_enable;
    assign load_clamped = ({1'b0, load_value} < MOD_W) ? load_value : TOP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            count     <= '0;
            box_count <= '0;
            box_done  <= 1'b0;
            box_full  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            s1       <= sensor_in;
            s2       <= s1;
            s3       <= s2;
            box_done <= 1'b0;
            if (clear) begin
                count     <= '0;
                box_count <= '0;
                box_full  <= 1'b0;
                underflow <= 1'b0;
            end else if (load) begin
                count <= load_clamped;
            end else if (bottle_ev) begin
                if (!dir) begin
                    if (count == TOP) begin
                        count    <= '0;
                        box_done <= 1'b1;
                        if (box_count == BOX_MAX) begin
                            box_full <= 1'b1;
                        end else begin
                            box_count <= box_count + 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    if (count == '0) begin
                        underflow <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bottle_box_counter.sv
// tb_bottle_box_counter: directed scenarios plus random traffic against
// a sample-history reference model of the bottle/box counter.
module tb_bottle_box_counter;

    localparam int W    = 8;
    localparam int MOD  = 12;
    localparam int BW   = 2;
    localparam int BMAX = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          count_enable = 1'b1;
    logic          sensor_in = 1'b0;
    logic          dir = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic [W-1:0]  count;
    logic [BW-1:0] box_count;
    logic          box_done;
    logic          box_full;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    int m_count;
    int m_box;
    bit m_done;
    bit m_full;
    bit m_uf;
    bit sq[$];

    bottle_box_counter #(
        .WIDTH(W),
        .MODULO(MOD),
        .BOX_WIDTH(BW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .count_enable(count_enable),
        .sensor_in(sensor_in),
        .dir(dir),
        .load(load),
        .load_value(load_value),
        .count(count),
        .box_count(box_count),
        .box_done(box_done),
        .box_full(box_full),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_count = 0;
        m_box   = 0;
        m_done  = 0;
        m_full  = 0;
        m_uf    = 0;
        sq      = '{1'b1, 1'b1, 1'b1};
    endfunction

    initial m_reset();

    always @(negedge reset) m_reset();

    // sq[0..2] = sensor samples taken 1, 2, 3 edges ago.
    always @(posedge clk) begin
        bit ev;
        if (!reset) begin
            m_reset();
        end else begin
            ev = sq[1] && !sq[2] && count_enable;
            m_done = 0;
            if (clear) begin
                m_count = 0;
                m_box   = 0;
                m_full  = 0;
                m_uf    = 0;
            end else if (load) begin
                m_count = (int'(load_value) < MOD) ? int'(load_value) : MOD - 1;
            end else if (ev && !dir) begin
                m_count = (m_count + 1) % MOD;
                if (m_count == 0) begin
                    m_done = 1;
                    if (m_box == BMAX) m_full = 1;
                    else m_box = m_box + 1;
                end
            end else if (ev && dir) begin
                if (m_count == 0) m_uf = 1;
                else m_count = m_count - 1;
            end
            sq.push_front(sensor_in);
            void'(sq.pop_back());
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count", int'(count), m_count);
        chk("box_count", int'(box_count), m_box);
        chk("box_done", int'(box_done), int'(m_done));
        chk("box_full", int'(box_full), int'(m_full));
        chk("underflow", int'(underflow), int'(m_uf));
        if (box_done === 1'b1) n_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input int hi, input int lo);
        sensor_in = 1'b1;
        repeat (hi) tick();
        sensor_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_value = W'(v);
        tick();
        load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check_all();
        chk("rst_count", int'(count), 0);
        tick();
        reset = 1'b1;
        repeat (4) tick();

        // latency: sample at k, event after k+1, count at k+2
        sensor_in = 1'b1;
        tick();
        chk("lat_k", int'(count), 0);
        tick();
        chk("lat_k1", int'(count), 0);
        tick();
        chk("lat_k2", int'(count), 1);
        chk("lat_done", int'(box_done), 0);
        sensor_in = 1'b0;
        repeat (3) tick();

        // one full box
        do_clear();
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            pulse(3, 3);
            chk("wrap_step", int'(count), (i + 1) % MOD);
        end
        chk("wrap_pulses", n_done, 1);
        chk("wrap_box", int'(box_count), 1);

        // rejects down to underflow
        do_load(2);
        dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(3, 3);
            chk("rej_step", int'(count), (i == 0) ? 1 : 0);
        end
        chk("rej_uf", int'(underflow), 1);
        chk("rej_box", int'(box_count), 1);
        do_clear();
        chk("clr_uf", int'(underflow), 0);
        chk("clr_count", int'(count), 0);
        dir = 1'b0;

        // load clamp and load-over-event priority
        do_load(20);
        chk("clamp", int'(count), MOD - 1);
        sensor_in = 1'b1;
        tick();
        tick();
        do_load(5);
        chk("load_prio", int'(count), 5);
        sensor_in = 1'b0;
        repeat (3) tick();
        chk("no_late_ev", int'(count), 5);
        pulse(3, 3);
        chk("after_load", int'(count), 6);

        // box counter saturation
        do_clear();
        n_done = 0;
        repeat (48) pulse(3, 3);
        chk("sat_box", int'(box_count), BMAX);
        chk("sat_full", int'(box_full), 1);
        chk("sat_count", int'(count), 0);
        chk("sat_pulses", n_done, 4);

        // gating, async reset, sensor high across reset release
        do_load(3);
        count_enable = 1'b0;
        repeat (3) pulse(3, 3);
        chk("gated", int'(count), 3);
        count_enable = 1'b1;
        do_load(7);
        chk("pre_rst", int'(count), 7);
        #2 reset = 1'b0;
        #1;
        chk("async_rst", int'(count), 0);
        chk("async_full", int'(box_full), 0);
        sensor_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("held_sensor", int'(count), 0);
        sensor_in = 1'b0;
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            clear        = ($urandom_range(0, 63) == 0);
            load         = ($urandom_range(0, 31) == 0);
            load_value   = W'($urandom_range(0, 20));
            count_enable = ($urandom_range(0, 7) != 0);
            dir          = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) sensor_in = ~sensor_in;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #1 check_all();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
